morph_frame_ctrl: RTL and testbench
===================================

# morph_frame_ctrl

Frame-level sequencer for the binary morphology chain (erosion then dilation) in the frame-difference motion path. Tracks frame/line timing of the stream entering the chain, and applies per-stage bypass configuration only at frame boundaries so a frame is never processed half-configured. Holds `busy` until the chain's pipeline latency has drained, then emits `frame_done`. Sits beside the morphology blocks; its bypass outputs drive their stage-select muxes.

## Interface
- `IMG_HDISP`, 10'd640, expected clken pulses per line
- `IMG_VDISP`, 10'd480, expected lines per frame
- `PIPE_LAT`, 8'd16, drain cycles after vsync falls (≥1)
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, asynchronous, active-high
- `per_frame_vsync`  in  1  frame valid (high during frame)
- `per_frame_href`  in  1  line valid
- `per_frame_clken`  in  1  pixel valid
- `cfg_valid`  in  1  config offer
- `cfg_ready`  out  1  config slot free
- `cfg_erode_byp`, `cfg_dilate_byp`  in  1 each  requested bypass
- `erode_byp`, `dilate_byp`  out  1 each  applied bypass (frame-stable)
- `busy`  out  1  state ≠ IDLE
- `frame_start`, `frame_done`  out  1 each  single-cycle pulses
- `frame_cnt`  out  16  completed frames, wraps
- `err_clr`  in  1  clear sticky errors
- `err_hlen`, `err_vlen`, `err_ovl`  out  1 each  sticky errors

## Operation
- States: IDLE, ARM, ACTIVE, DRAIN. Edge detection via registered `vs_r`, `hs_r`.
- IDLE→ARM on edge where vsync=1 and vs_r=0. ARM: load `erode_byp/dilate_byp` from pending if pending valid, clear pending; `frame_start`=1; clear x/y counters. ARM→ACTIVE unconditionally.
- ACTIVE: x_cnt (10b, saturating 1023) increments on clken&href; on href falling, compare x_cnt to IMG_HDISP (mismatch → err_hlen), y_cnt++ (saturating), x_cnt←0. On vsync falling: compare y_cnt to IMG_VDISP (mismatch → err_vlen); drain_cnt←PIPE_LAT−1; →DRAIN.
- DRAIN: drain_cnt decrements; at 0 → IDLE, `frame_done`=1, frame_cnt++.
- vsync rising in DRAIN: `frame_done` pulses, frame_cnt++, err_ovl set, →ARM (drain aborted).
- Config handshake: transfer when cfg_valid&cfg_ready; `cfg_ready`=!pend_valid. One pending slot; applied at next ARM. Transfer on the same edge as ARM's load goes to the next frame.
- err_clr clears all sticky flags; a new error on the same edge wins (stays set).
- href/clken outside ACTIVE ignored.

## Timing
- Reset values: state IDLE, erode_byp=0, dilate_byp=0, busy=0, frame_start=0, frame_done=0, frame_cnt=0, cfg_ready=1, all err=0, pending cleared.
- frame_start and new bypass values visible the cycle after vsync is first sampled high; bypass stable until next ARM.
- frame_done asserted exactly PIPE_LAT+1 cycles after vsync is first sampled low (1 cycle ACTIVE→DRAIN, PIPE_LAT in DRAIN); busy deasserts with it.
- All outputs registered; no combinational input→output path except cfg_ready (registered pend_valid).
- Reset mid-frame: immediate return to reset values; pending config discarded; next frame starts only on a fresh vsync rising edge.

## Configuration
- `MORPH_CTRL_LENCHK_EN`: defined → x/y length comparison and err_hlen/err_vlen/err_ovl logic present. Undefined → these outputs tied 0, err_clr ignored, counters still present for sequencing; all other behaviour identical.

## Structure
- Package `morph_pkg`: state enum (IDLE/ARM/ACTIVE/DRAIN), `CNT_W`=10, `FCNT_W`=16, default PIPE_LAT constant.
- One sub-module: `morph_len_chk` (x/y counters, edge compare, sticky flags), instantiated under the macro.

## Test plan
- IMG_HDISP=8, IMG_VDISP=4, PIPE_LAT=3; clean frame (4 lines × 8 clken) → frame_start 1 cycle after vsync rise, frame_done 4 cycles after vsync fall, frame_cnt=1, no errors.
- cfg (erode_byp=1, dilate_byp=0) accepted mid-frame → cfg_ready=0, bypass unchanged until next frame_start, then erode_byp=1, cfg_ready=1.
- Line with 7 clken → err_hlen=1 after that href fall, sticky; err_clr → 0.
- Frame with 5 lines → err_vlen=1 at vsync fall; frame_done still after 4 cycles.
- vsync re-rises 1 cycle into DRAIN → frame_done pulse, err_ovl=1, frame_start next cycle, frame_cnt +1.
- rst asserted mid-ACTIVE with pending cfg → all outputs reset values immediately, cfg_ready=1; held-high vsync after reset does not start a frame.

Source files
------------

// File: rtl/morph_pkg.sv
// ---------------------------------------------------------------------------
// morph_pkg
// Shared types and constants for the morphology-chain frame sequencer.
//   state_t      : sequencer states (IDLE, ARM, ACTIVE, DRAIN)
//   CNT_W        : width of the x/y pixel/line counters
//   FCNT_W       : width of the completed-frame counter
//   PIPE_LAT_DEF : default drain latency of the erosion/dilation chain
//   sat_inc()    : saturating increment for the x/y counters
// ---------------------------------------------------------------------------
package morph_pkg;

    localparam int          CNT_W        = 10;
    localparam int          FCNT_W       = 16;
    localparam logic [7:0]  PIPE_LAT_DEF = 8'd16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/morph_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// morph_frame_ctrl_if
// Video timing stream entering the morphology chain plus the bypass
// configuration handshake.
//   per_frame_vsync/href/clken : frame / line / pixel valid
//   cfg_valid, cfg_ready       : config offer / pending slot free
//   cfg_erode_byp/dilate_byp   : requested per-stage bypass
// Modports: master drives stream and config, slave is the sequencer.
// ---------------------------------------------------------------------------
interface morph_frame_ctrl_if;

    logic per_frame_vsync;
    logic per_frame_href;
    logic per_frame_clken;
    logic cfg_valid;
    logic cfg_ready;
    logic cfg_erode_byp;
    logic cfg_dilate_byp;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken,
        output cfg_valid, cfg_erode_byp, cfg_dilate_byp,
        input  cfg_ready
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken,
        input  cfg_valid, cfg_erode_byp, cfg_dilate_byp,
        output cfg_ready
    );

endinterface

// File: rtl/morph_len_chk.sv
// ---------------------------------------------------------------------------
// morph_len_chk
// Line/frame length checker for the morphology sequencer. Counts accepted
// pixels per line and lines per frame while the sequencer is ACTIVE and
// raises sticky errors on length mismatch or on a frame that overlapped
// the previous frame's drain.
// Ports:
//   clk, rst             : clock, async active-high reset
//   active               : sequencer is in ACTIVE
//   clear                : sequencer is in ARM (zero x/y counters)
//   pix                  : href & clken this cycle
//   hs_fall, vs_fall     : href / vsync falling edge this cycle
//   ovl                  : vsync rose during DRAIN this cycle
//   err_clr              : clear all sticky errors
//   err_hlen/vlen/ovl    : sticky error flags
// ---------------------------------------------------------------------------
module morph_len_chk
    import morph_pkg::*;
#(
    parameter logic [CNT_W-1:0] IMG_HDISP = 10'd640,
    parameter logic [CNT_W-1:0] IMG_VDISP = 10'd480
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    input  logic pix,
    input  logic hs_fall,
    input  logic vs_fall,
    input  logic ovl,
    input  logic err_clr,
    output logic err_hlen,
    output logic err_vlen,
    output logic err_ovl
);

    logic [CNT_W-1:0] x_cnt;
    logic [CNT_W-1:0] y_cnt;
    logic [CNT_W-1:0] y_eff;
    logic             line_end;
    logic             hlen_ev;
    logic             vlen_ev;

    assign line_end = active && hs_fall;
    // A line closing on the same edge as the frame still counts toward it.
    assign y_eff    = line_end ? sat_inc(y_cnt) : y_cnt;
    assign hlen_ev  = line_end && (x_cnt != IMG_HDISP);
    assign vlen_ev  = active && vs_fall && (y_eff != IMG_VDISP);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (clear) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (active) begin
            if (hs_fall) begin
                x_cnt <= '0;
                y_cnt <= sat_inc(y_cnt);
            end else if (pix) begin
                x_cnt <= sat_inc(x_cnt);
            end
        end
    end

    // Clear and a new error on the same edge: the new error stays set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_hlen <= 1'b0;
            err_vlen <= 1'b0;
            err_ovl  <= 1'b0;
        end else begin
            err_hlen <= (err_hlen && !err_clr) || hlen_ev;
            err_vlen <= (err_vlen && !err_clr) || vlen_ev;
            err_ovl  <= (err_ovl  && !err_clr) || ovl;
        end
    end

endmodule

// File: rtl/morph_frame_ctrl.sv
// ---------------------------------------------------------------------------
// morph_frame_ctrl
// Frame-level sequencer for the erosion->dilation chain. Applies per-stage
// bypass only at frame start, holds busy until the chain latency has
// drained, and reports frame_start / frame_done pulses.
// Optional feature macro: MORPH_CTRL_LENCHK_EN
//   defined   -> line/frame length checks and sticky error flags
//   undefined -> err_* tied low, err_clr ignored
// Ports:
//   clk, rst                 : clock, async active-high reset
//   bus (slave)              : vsync/href/clken stream, cfg handshake
//   erode_byp, dilate_byp    : applied bypass, stable for a whole frame
//   busy                     : sequencer not idle
//   frame_start, frame_done  : single-cycle pulses
//   frame_cnt                : completed frames, wraps
//   err_clr                  : clear sticky errors
//   err_hlen, err_vlen, err_ovl : sticky errors
// ---------------------------------------------------------------------------
module morph_frame_ctrl
    import morph_pkg::*;
#(
    parameter logic [CNT_W-1:0] IMG_HDISP = 10'd640,
    parameter logic [CNT_W-1:0] IMG_VDISP = 10'd480,
    parameter logic [7:0]       PIPE_LAT  = PIPE_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    morph_frame_ctrl_if.slave   bus,
    output logic                erode_byp,
    output logic                dilate_byp,
    output logic                busy,
    output logic                frame_start,
    output logic                frame_done,
    output logic [FCNT_W-1:0]   frame_cnt,
    input  logic                err_clr,
    output logic                err_hlen,
    output logic                err_vlen,
    output logic                err_ovl
);

    state_t     state;
    state_t     state_nxt;
    logic       vs_r;
    logic       hs_r;
    logic       vs_rise;
    logic       vs_fall;
    logic       hs_fall;
    logic       pix;
    logic [7:0] drain_cnt;
    logic       done_ev;
    logic       ovl_ev;
    logic       pend_valid;
    logic       pend_erode;
    logic       pend_dilate;
    logic       cfg_xfer;
    logic       arm_load;

    assign vs_rise  = bus.per_frame_vsync && !vs_r;
    assign vs_fall  = !bus.per_frame_vsync && vs_r;
    assign hs_fall  = !bus.per_frame_href && hs_r;
    assign pix      = bus.per_frame_href && bus.per_frame_clken;

    assign bus.cfg_ready = !pend_valid;
    assign cfg_xfer      = bus.cfg_valid && !pend_valid;
    // Slot is either loaded or refilled on a given edge, never both, so a
    // transfer coinciding with ARM waits for the following frame.
    assign arm_load      = (state_nxt == ARM) && pend_valid;

    // NOTE: every output of this block gets a default before the case so
    // no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        done_ev   = 1'b0;
        ovl_ev    = 1'b0;
        case (state)
            IDLE:   if (vs_rise) state_nxt = ARM;
            ARM:    state_nxt = ACTIVE;
            ACTIVE: if (vs_fall) state_nxt = DRAIN;
            DRAIN: begin
                if (vs_rise) begin
                    // New frame arrived before the chain drained: close the
                    // old frame now and start the new one.
                    state_nxt = ARM;
                    done_ev   = 1'b1;
                    ovl_ev    = 1'b1;
                end else if (drain_cnt == 8'd0) begin
                    state_nxt = IDLE;
                    done_ev   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // vs_r resets high so a vsync already high when reset releases is not
    // mistaken for a frame start; only a fresh rising edge arms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vs_r      <= 1'b1;
            hs_r      <= 1'b0;
            drain_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            vs_r  <= bus.per_frame_vsync;
            hs_r  <= bus.per_frame_href;
            if (state == ACTIVE && vs_fall)
                drain_cnt <= PIPE_LAT - 8'd1;
            else if (state == DRAIN && drain_cnt != 8'd0)
                drain_cnt <= drain_cnt - 8'd1;
        end
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            busy        <= (state_nxt != IDLE);
            frame_start <= (state_nxt == ARM);
            frame_done  <= done_ev;
            if (done_ev)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // NOTE: the pending slot is reset explicitly so a reset discards any
    // queued configuration rather than applying it to the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid  <= 1'b0;
            pend_erode  <= 1'b0;
            pend_dilate <= 1'b0;
            erode_byp   <= 1'b0;
            dilate_byp  <= 1'b0;
        end else begin
            if (arm_load) begin
                erode_byp  <= pend_erode;
                dilate_byp <= pend_dilate;
            end
            if (cfg_xfer) begin
                pend_valid  <= 1'b1;
                pend_erode  <= bus.cfg_erode_byp;
                pend_dilate <= bus.cfg_dilate_byp;
            end else if (arm_load) begin
                pend_valid <= 1'b0;
            end
        end
    end

`ifdef MORPH_CTRL_LENCHK_EN
    morph_len_chk #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP)
    ) u_len_chk (
        .clk      (clk),
        .rst      (rst),
        .active   (state == ACTIVE),
        .clear    (state == ARM),
        .pix      (pix),
        .hs_fall  (hs_fall),
        .vs_fall  (vs_fall),
        .ovl      (ovl_ev),
        .err_clr  (err_clr),
        .err_hlen (err_hlen),
        .err_vlen (err_vlen),
        .err_ovl  (err_ovl)
    );
`else
    assign err_hlen = 1'b0;
    assign err_vlen = 1'b0;
    assign err_ovl  = 1'b0;

    logic unused_lenchk;
    assign unused_lenchk = ^{err_clr, hs_fall, pix, ovl_ev, IMG_HDISP, IMG_VDISP};
`endif

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_morph_frame_ctrl
// Self-checking bench for morph_frame_ctrl with a small image (8x4) and
// PIPE_LAT=3. A frame-level model tracks applied/pending bypass, completed
// frame count and expected sticky errors; DUT outputs are compared at the
// negative clock edge, inputs change there too.
// ---------------------------------------------------------------------------
module tb_morph_frame_ctrl;
    import morph_pkg::*;

    localparam logic [CNT_W-1:0] HD  = 10'd8;
    localparam logic [CNT_W-1:0] VD  = 10'd4;
    localparam logic [7:0]       PL  = 8'd3;
    localparam int               HDI = 8;
    localparam int               VDI = 4;
    localparam int               PLI = 3;

`ifdef MORPH_CTRL_LENCHK_EN
    localparam bit LENCHK = 1'b1;
`else
    localparam bit LENCHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              err_clr;
    logic              erode_byp, dilate_byp, busy, frame_start, frame_done;
    logic [FCNT_W-1:0] frame_cnt;
    logic              err_hlen, err_vlen, err_ovl;

    always #5 clk = ~clk;

    morph_frame_ctrl_if bus ();

    morph_frame_ctrl #(
        .IMG_HDISP (HD),
        .IMG_VDISP (VD),
        .PIPE_LAT  (PL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .erode_byp   (erode_byp),
        .dilate_byp  (dilate_byp),
        .busy        (busy),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .err_clr     (err_clr),
        .err_hlen    (err_hlen),
        .err_vlen    (err_vlen),
        .err_ovl     (err_ovl)
    );

    // Reference model state
    bit              m_e, m_d;
    bit              m_pv, m_pe, m_pd;
    bit              m_hlen, m_vlen, m_ovl;
    logic [FCNT_W-1:0] m_fcnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_e = 0; m_d = 0; m_pv = 0; m_pe = 0; m_pd = 0;
        m_hlen = 0; m_vlen = 0; m_ovl = 0; m_fcnt = '0;
    endtask

    // Frame start: a queued config becomes active; an offer on this same
    // edge only fills the (then free) slot for the following frame.
    task automatic model_arm(input bit offer, input bit oe, input bit od);
        bit acc;
        acc = offer && !m_pv;
        if (m_pv) begin
            m_e = m_pe; m_d = m_pd; m_pv = 0;
        end
        if (acc) begin
            m_pv = 1; m_pe = oe; m_pd = od;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ":erode_byp"},  erode_byp,     m_e);
        check({tag, ":dilate_byp"}, dilate_byp,    m_d);
        check({tag, ":frame_cnt"},  frame_cnt,     m_fcnt);
        check({tag, ":cfg_ready"},  bus.cfg_ready, !m_pv);
        check({tag, ":err_hlen"},   err_hlen,      m_hlen);
        check({tag, ":err_vlen"},   err_vlen,      m_vlen);
        check({tag, ":err_ovl"},    err_ovl,       m_ovl);
    endtask

    task automatic start_frame(input bit allow_offer);
        bit offer, oe, od;
        bus.per_frame_href  = 0;
        bus.per_frame_clken = 1'($urandom);
        step();
        check("pre_start:frame_start", frame_start, 0);
        check("pre_start:busy", busy, 0);
        offer = allow_offer && ($urandom_range(0, 2) == 0);
        oe = 1'($urandom); od = 1'($urandom);
        bus.cfg_valid = offer; bus.cfg_erode_byp = oe; bus.cfg_dilate_byp = od;
        bus.per_frame_vsync = 1;
        step();
        bus.cfg_valid = 0;
        model_arm(offer, oe, od);
        check("start:frame_start", frame_start, 1);
        check("start:busy", busy, 1);
        check_state("start");
        step();
        check("start+1:frame_start", frame_start, 0);
    endtask

    task automatic drive_line(input int npix);
        int cnt;
        bit c;
        repeat ($urandom_range(0, 2)) begin
            bus.per_frame_href = 0; bus.per_frame_clken = 1'($urandom);
            step();
        end
        bus.per_frame_href = 1;
        cnt = 0;
        while (cnt < npix) begin
            c = ($urandom_range(0, 3) != 0);
            bus.per_frame_clken = c;
            if (c) cnt++;
            step();
        end
        bus.per_frame_href = 0; bus.per_frame_clken = 1'($urandom);
        step();
        if (LENCHK && npix != HDI) m_hlen = 1;
        check("line:busy", busy, 1);
        check("line:frame_done", frame_done, 0);
        check_state("line");
    endtask

    task automatic frame_body(input int nlines, input int bad_line, input int bad_len,
                              input int cfg_line, input bit fixed, input bit fe, input bit fd);
        bit oe, od;
        for (int l = 0; l < nlines; l++) begin
            if (l == cfg_line) begin
                oe = fixed ? fe : 1'($urandom);
                od = fixed ? fd : 1'($urandom);
                bus.per_frame_href = 0;
                bus.cfg_valid = 1; bus.cfg_erode_byp = oe; bus.cfg_dilate_byp = od;
                step();
                bus.cfg_valid = 0;
                if (!m_pv) begin
                    m_pv = 1; m_pe = oe; m_pd = od;
                end
                check_state("cfg_mid");
            end
            drive_line((l == bad_line) ? bad_len : HDI);
        end
    endtask

    // ovl_at = 0: normal drain; ovl_at = j (1..PL): vsync re-rises so that
    // the rise is sampled j edges after the fall was sampled.
    task automatic end_frame(input int nlines, input int ovl_at);
        bus.per_frame_href = 0;
        bus.per_frame_vsync = 0;
        step();
        if (LENCHK && nlines != VDI) m_vlen = 1;
        check("fall:busy", busy, 1);
        check("fall:frame_done", frame_done, 0);
        check_state("fall");
        for (int k = 2; k <= PLI + 1; k++) begin
            if (ovl_at != 0 && k == ovl_at + 1) begin
                bus.per_frame_vsync = 1;
                step();
                m_fcnt++;
                if (LENCHK) m_ovl = 1;
                model_arm(0, 0, 0);
                check("ovl:frame_done", frame_done, 1);
                check("ovl:frame_start", frame_start, 1);
                check("ovl:busy", busy, 1);
                check_state("ovl");
                step();
                check("ovl+1:frame_start", frame_start, 0);
                check("ovl+1:frame_done", frame_done, 0);
                return;
            end
            step();
            if (k == PLI + 1) m_fcnt++;
            check("drain:frame_done", frame_done, (k == PLI + 1));
            check("drain:busy", busy, (k != PLI + 1));
            check_state("drain");
        end
        step();
        check("done+1:frame_done", frame_done, 0);
        check("done+1:busy", busy, 0);
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(1, 4)) begin
            bus.per_frame_href = 1'($urandom); bus.per_frame_clken = 1'($urandom);
            step();
            check("idle:busy", busy, 0);
            check("idle:frame_start", frame_start, 0);
        end
        bus.per_frame_href = 0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1;
        step();
        err_clr = 0;
        if (LENCHK) begin
            m_hlen = 0; m_vlen = 0; m_ovl = 0;
        end
        check_state("err_clr");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        int nl, bl, blen, cl, ov;
        bit in_frame;

        rst = 1; err_clr = 0;
        bus.per_frame_vsync = 0; bus.per_frame_href = 0; bus.per_frame_clken = 0;
        bus.cfg_valid = 0; bus.cfg_erode_byp = 0; bus.cfg_dilate_byp = 0;
        model_reset();
        #1;
        check_state("reset");
        check("reset:busy", busy, 0);
        check("reset:frame_start", frame_start, 0);
        check("reset:frame_done", frame_done, 0);
        step(); step();
        rst = 0;
        step();

        // Clean frame with a mid-frame config (erode=1, dilate=0)
        start_frame(0);
        frame_body(VDI, -1, HDI, 1, 1, 1, 0);
        end_frame(VDI, 0);
        // Next frame picks up the config; one short (7-pixel) line
        start_frame(0);
        frame_body(VDI, 2, 7, -1, 0, 0, 0);
        end_frame(VDI, 0);
        pulse_err_clr();
        // Five-line frame
        start_frame(0);
        frame_body(5, -1, HDI, -1, 0, 0, 0);
        end_frame(5, 0);
        pulse_err_clr();
        // vsync re-rises one cycle into drain
        start_frame(0);
        frame_body(VDI, -1, HDI, 0, 0, 0, 0);
        end_frame(VDI, 1);
        frame_body(VDI, -1, HDI, -1, 0, 0, 0);
        end_frame(VDI, 0);

        // Randomized frames
        in_frame = 0;
        for (int f = 0; f < 14; f++) begin
            nl   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 5)) : VDI;
            bl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            blen = ($urandom_range(0, 1) == 0) ? 7 : 9;
            cl   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            ov   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, PLI)) : 0;
            if (!in_frame) start_frame(1);
            frame_body(nl, bl, blen, cl, 0, 0, 0);
            end_frame(nl, ov);
            in_frame = (ov != 0);
            if (!in_frame) begin
                idle_gap();
                if ($urandom_range(0, 2) == 0) pulse_err_clr();
            end
        end
        if (in_frame) begin
            frame_body(VDI, -1, HDI, -1, 0, 0, 0);
            end_frame(VDI, 0);
        end

        // Reset in the middle of an active line with a config pending
        start_frame(0);
        frame_body(2, -1, HDI, 0, 1, 1, 1);
        bus.per_frame_href = 1; bus.per_frame_clken = 1;
        step();
        check("pre_rst:cfg_ready", bus.cfg_ready, 0);
        rst = 1;
        #1;
        model_reset();
        check_state("mid_rst");
        check("mid_rst:busy", busy, 0);
        check("mid_rst:frame_start", frame_start, 0);
        check("mid_rst:frame_done", frame_done, 0);
        step();
        rst = 0;
        bus.per_frame_href = 0; bus.per_frame_clken = 0;
        repeat (4) begin
            step();
            check("post_rst:frame_start", frame_start, 0);
            check("post_rst:busy", busy, 0);
        end
        bus.per_frame_vsync = 0;
        step();
        start_frame(0);
        frame_body(VDI, -1, HDI, -1, 0, 0, 0);
        end_frame(VDI, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
